vga_text_scanner: RTL and testbench

Pixel-timing and text-cell addressing stage running on the 25 MHz pixel clock. It produces the raster counters and the VGA sync and blank strobes. It also maps the current pixel onto the 11-character text line held in TopRam: character index, glyph row and glyph column. The pixel renderer downstream uses these to look up the char byte and font bit. Sync and blank outputs are delayed to line up with the renderer's pipeline.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/sync_delay_line.sv | 27 ++
 rtl/vga_text_scanner.sv | 108 ++++++++++
 tb/tb_vga_text_scanner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// 640x480@60 raster timing and text-cell geometry shared by the scanner and its sub-blocks.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CELL_W    = 8;
  localparam int CELL_LOG2 = 3;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that delays sync/blank strobes; freezes when enable is low.
module sync_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (enable) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_text_scanner.sv
// Raster counters, delayed VGA sync/blank, and zero-latency mapping of the pixel onto the text line.
module vga_text_scanner
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int N_CHARS    = 11,
  parameter int SCALE_LOG2 = 2,
  parameter int TEXT_X0    = 144,
  parameter int TEXT_Y0    = 224,
  parameter int PIPE       = 2
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       in_text,
  output logic [3:0] char_idx,
  output logic [2:0] glyph_row,
  output logic [2:0] glyph_col,
  output logic       hsync,
  output logic       vsync,
  output logic       n_blank,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CELL_SHIFT = CELL_LOG2 + SCALE_LOG2;
  localparam int TEXT_W     = N_CHARS << CELL_SHIFT;
  localparam int TEXT_H     = CELL_W << SCALE_LOG2;

  if (PIPE < 1 || N_CHARS > 15 || TEXT_X0 + TEXT_W > H_ACTIVE ||
      TEXT_Y0 + TEXT_H > V_ACTIVE) begin : g_bad_cfg
    $fatal(1, "vga_text_scanner: text box outside active area, N_CHARS > 15 or PIPE < 1");
  end

  logic h_end, v_end;
  assign h_end = (hcount == coord_t'(H_TOTAL - 1));
  assign v_end = (vcount == coord_t'(V_TOTAL - 1));

  always_ff @(posedge clock_25) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      frame_start <= h_end && v_end;
      if (h_end) begin
        hcount <= '0;
        if (v_end) begin
          vcount      <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          vcount <= vcount + 10'd1;
        end
      end else begin
        hcount <= hcount + 10'd1;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

  logic hs0, vs0, bl0;
  assign hs0 = !((hcount >= coord_t'(H_ACTIVE + H_FP)) &&
                 (hcount <  coord_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs0 = !((vcount >= coord_t'(V_ACTIVE + V_FP)) &&
                 (vcount <  coord_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign bl0 = (hcount < coord_t'(H_ACTIVE)) && (vcount < coord_t'(V_ACTIVE));

  // Idle pattern {hsync, vsync, n_blank} = 1,1,0 fills the pipe on reset.
  logic [2:0] strobe_q;
  sync_delay_line #(
    .DEPTH     (PIPE),
    .WIDTH     (3),
    .RESET_VAL (3'b110)
  ) u_sync_delay (
    .clk    (clock_25),
    .reset  (reset),
    .enable (enable),
    .d      ({hs0, vs0, bl0}),
    .q      (strobe_q)
  );
  assign {hsync, vsync, n_blank} = strobe_q;

  // dx/dy wrap to large values left of / above the box, so the upper bound alone rejects them.
  coord_t dx, dy;
  assign dx = hcount - coord_t'(TEXT_X0);
  assign dy = vcount - coord_t'(TEXT_Y0);

  assign in_text = (hcount >= coord_t'(TEXT_X0)) && (dx < coord_t'(TEXT_W)) &&
                   (vcount >= coord_t'(TEXT_Y0)) && (dy < coord_t'(TEXT_H));

  assign char_idx  = in_text ? 4'(dx >> CELL_SHIFT) : 4'd0;
  assign glyph_col = in_text ? dx[SCALE_LOG2+2:SCALE_LOG2] : 3'd0;
  assign glyph_row = in_text ? dy[SCALE_LOG2+2:SCALE_LOG2] : 3'd0;

endmodule

// File: tb/tb_vga_text_scanner.sv
// Randomized-enable bench for vga_text_scanner: two configurations checked every cycle against
// a model that derives every output from the count of enabled cycles since reset.
module tb_vga_text_scanner;

  logic clock_25 = 1'b0;
  always #20 clock_25 = ~clock_25;

  logic reset  = 1'b1;
  logic enable = 1'b0;

  // Instance A: default timing, text box moved up to line 4 so it is reached in a short run.
  localparam int A_Y0 = 4;
  logic [9:0] a_hcount, a_vcount;
  logic       a_in_text, a_hsync, a_vsync, a_n_blank, a_frame_start;
  logic [3:0] a_char_idx;
  logic [2:0] a_glyph_row, a_glyph_col;
  logic [7:0] a_frame_count;

  vga_text_scanner #(.TEXT_Y0(A_Y0)) dut_a (
    .clock_25    (clock_25),
    .reset       (reset),
    .enable      (enable),
    .hcount      (a_hcount),
    .vcount      (a_vcount),
    .in_text     (a_in_text),
    .char_idx    (a_char_idx),
    .glyph_row   (a_glyph_row),
    .glyph_col   (a_glyph_col),
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .n_blank     (a_n_blank),
    .frame_start (a_frame_start),
    .frame_count (a_frame_count)
  );

  // Instance B: tiny 24x12 raster so many frame wraps happen; PIPE=1, unscaled glyphs.
  logic [9:0] b_hcount, b_vcount;
  logic       b_in_text, b_hsync, b_vsync, b_n_blank, b_frame_start;
  logic [3:0] b_char_idx;
  logic [2:0] b_glyph_row, b_glyph_col;
  logic [7:0] b_frame_count;

  vga_text_scanner #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .N_CHARS(1), .SCALE_LOG2(0), .TEXT_X0(4), .TEXT_Y0(0), .PIPE(1)
  ) dut_b (
    .clock_25    (clock_25),
    .reset       (reset),
    .enable      (enable),
    .hcount      (b_hcount),
    .vcount      (b_vcount),
    .in_text     (b_in_text),
    .char_idx    (b_char_idx),
    .glyph_row   (b_glyph_row),
    .glyph_col   (b_glyph_col),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .n_blank     (b_n_blank),
    .frame_start (b_frame_start),
    .frame_count (b_frame_count)
  );

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, n, sl, x0, y0, pipe;
  } cfg_t;

  typedef struct {
    logic [31:0] hcount, vcount, in_text, char_idx, row, col;
    logic [31:0] hsync, vsync, n_blank, frame_start, frame_count;
  } obs_t;

  cfg_t cfg_a, cfg_b;
  int   t;        // enabled cycles since the last reset
  logic last_en;  // last edge advanced the raster
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0d)", tag, got, exp, t);
  endtask

  function automatic obs_t model(input cfg_t c, input int tt, input logic adv);
    obs_t m;
    int ht, vt, fr, h, v, s, tp, hp, vp;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    fr = ht * vt;
    s  = 1 << c.sl;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    m.hcount      = h;
    m.vcount      = v;
    m.frame_count = (tt / fr) % 256;
    m.frame_start = (adv && tt > 0 && (tt % fr) == 0) ? 1 : 0;
    if (h >= c.x0 && h < c.x0 + c.n * 8 * s && v >= c.y0 && v < c.y0 + 8 * s) begin
      m.in_text  = 1;
      m.char_idx = (h - c.x0) / (8 * s);
      m.col      = ((h - c.x0) / s) % 8;
      m.row      = ((v - c.y0) / s) % 8;
    end else begin
      m.in_text  = 0;
      m.char_idx = 0;
      m.col      = 0;
      m.row      = 0;
    end
    if (tt < c.pipe) begin
      m.hsync   = 1;
      m.vsync   = 1;
      m.n_blank = 0;
    end else begin
      tp = tt - c.pipe;
      hp = tp % ht;
      vp = (tp / ht) % vt;
      m.hsync   = (hp >= c.ha + c.hf && hp < c.ha + c.hf + c.hs) ? 0 : 1;
      m.vsync   = (vp >= c.va + c.vf && vp < c.va + c.vf + c.vs) ? 0 : 1;
      m.n_blank = (hp < c.ha && vp < c.va) ? 1 : 0;
    end
    return m;
  endfunction

  task automatic compare(input string p, input obs_t o, input obs_t e);
    check({p, ".hcount"},      o.hcount,      e.hcount);
    check({p, ".vcount"},      o.vcount,      e.vcount);
    check({p, ".in_text"},     o.in_text,     e.in_text);
    check({p, ".char_idx"},    o.char_idx,    e.char_idx);
    check({p, ".glyph_row"},   o.row,         e.row);
    check({p, ".glyph_col"},   o.col,         e.col);
    check({p, ".hsync"},       o.hsync,       e.hsync);
    check({p, ".vsync"},       o.vsync,       e.vsync);
    check({p, ".n_blank"},     o.n_blank,     e.n_blank);
    check({p, ".frame_start"}, o.frame_start, e.frame_start);
    check({p, ".frame_count"}, o.frame_count, e.frame_count);
  endtask

  task automatic step(input logic rst, input logic en);
    obs_t oa, ob;
    reset  = rst;
    enable = en;
    @(posedge clock_25);
    #1;
    if (rst) begin
      t       = 0;
      last_en = 1'b0;
    end else begin
      if (en) t++;
      last_en = en;
    end
    oa = '{32'(a_hcount), 32'(a_vcount), 32'(a_in_text), 32'(a_char_idx),
           32'(a_glyph_row), 32'(a_glyph_col), 32'(a_hsync), 32'(a_vsync),
           32'(a_n_blank), 32'(a_frame_start), 32'(a_frame_count)};
    ob = '{32'(b_hcount), 32'(b_vcount), 32'(b_in_text), 32'(b_char_idx),
           32'(b_glyph_row), 32'(b_glyph_col), 32'(b_hsync), 32'(b_vsync),
           32'(b_n_blank), 32'(b_frame_start), 32'(b_frame_count)};
    compare("a", oa, model(cfg_a, t, last_en));
    compare("b", ob, model(cfg_b, t, last_en));
  endtask

  initial begin
    cfg_a   = '{640, 16, 96, 48, 480, 10, 2, 33, 11, 2, 144, A_Y0, 2};
    cfg_b   = '{16, 2, 4, 2, 8, 1, 2, 1, 1, 0, 4, 0, 1};
    t       = 0;
    last_en = 1'b0;

    repeat (3) step(1'b1, 1'b1);
    // Unbroken start so the first PIPE cycles and first active run are seen cleanly.
    repeat (700) step(1'b0, 1'b1);
    // Sweep past the text box lines with sporadic enable gaps.
    for (int i = 0; i < 33000; i++) step(1'b0, $urandom_range(0, 15) != 0);
    repeat (10) step(1'b0, 1'b0);
    repeat (200) step(1'b0, 1'b1);
    // Reset mid-frame, then random enable with rare resets.
    step(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 7) != 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
